// File: rtl/writeback_arbiter.sv
// writeback_arbiter: picks one completed result per cycle from p_num_pipes
// functional-unit pipes, holds it in a single output register and drives the
// regfile write port plus the commit notification to the in-order tracker.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default build uses fixed priority, lowest pipe index wins).
module writeback_arbiter #(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_addr_bits    = 5,
  parameter int unsigned p_data_bits    = 32,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [p_num_pipes-1:0]                      pipe_val,
  output logic [p_num_pipes-1:0]                      pipe_rdy,
  input  logic [p_num_pipes-1:0][p_addr_bits-1:0]     pipe_waddr,
  input  logic [p_num_pipes-1:0][p_data_bits-1:0]     pipe_wdata,
  input  logic [p_num_pipes-1:0]                      pipe_wen,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]  pipe_seq_num,
  output logic [p_addr_bits-1:0]                      rf_waddr,
  output logic [p_data_bits-1:0]                      rf_wdata,
  output logic                                        rf_wen,
  output logic                                        commit_val,
  input  logic                                        commit_rdy,
  output logic [p_seq_num_bits-1:0]                   commit_seq_num
);

  localparam int unsigned ptr_bits = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic                      out_val_q,   out_val_d;
  logic [p_addr_bits-1:0]    out_waddr_q, out_waddr_d;
  logic [p_data_bits-1:0]    out_wdata_q, out_wdata_d;
  logic                      out_wen_q,   out_wen_d;
  logic [p_seq_num_bits-1:0] out_seq_q,   out_seq_d;

  logic [p_num_pipes-1:0] grant;
  logic [ptr_bits-1:0]    grant_idx;
  logic                   any_val;
  logic                   fire;
  logic                   accept;
  logic                   xfer;
  int unsigned            arb_idx;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [ptr_bits-1:0] ptr_q, ptr_d;
`endif

  // Arbitration: one-hot grant from pipe_val and pointer only, never commit_rdy
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_val   = 1'b0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < p_num_pipes; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      arb_idx = (32'(ptr_q) + k) % p_num_pipes;
`else
      arb_idx = k;
`endif
      if (!any_val && pipe_val[ptr_bits'(arb_idx)]) begin
        any_val                     = 1'b1;
        grant[ptr_bits'(arb_idx)]   = 1'b1;
        grant_idx                   = ptr_bits'(arb_idx);
      end
    end
  end

  // Handshake and next-state for the output register (and pointer)
  always_comb begin
    fire        = out_val_q & commit_rdy;
    accept      = ~out_val_q | fire;
    xfer        = any_val & accept & ~rst;
    pipe_rdy    = rst ? '0 : (grant & {p_num_pipes{accept}});
    out_val_d   = out_val_q;
    out_waddr_d = out_waddr_q;
    out_wdata_d = out_wdata_q;
    out_wen_d   = out_wen_q;
    out_seq_d   = out_seq_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    if (xfer) begin
      out_val_d   = 1'b1;
      out_waddr_d = pipe_waddr[grant_idx];
      out_wdata_d = pipe_wdata[grant_idx];
      out_wen_d   = pipe_wen[grant_idx];
      out_seq_d   = pipe_seq_num[grant_idx];
`ifdef WB_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_bits'((32'(grant_idx) + 32'd1) % p_num_pipes);
`endif
    end else if (fire) begin
      out_val_d = 1'b0;
    end
  end

  // Output register; reset discards any held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val_q   <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
      out_wen_q   <= 1'b0;
      out_seq_q   <= '0;
    end else begin
      out_val_q   <= out_val_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
      out_wen_q   <= out_wen_d;
      out_seq_q   <= out_seq_d;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: moves past the pipe that just transferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Regfile write only on fire, so a stalled commit never writes twice; r0 is never written
  assign rf_wen         = fire & out_wen_q & (out_waddr_q != '0);
  assign rf_waddr       = out_waddr_q;
  assign rf_wdata       = out_wdata_q;
  assign commit_val     = out_val_q;
  assign commit_seq_num = out_seq_q;

endmodule
